issue_ctrl: RTL and testbench

Issue controller between the instruction decoder and the execute stage. It uses the decoder's register indices and enables to track pending writebacks in a scoreboard, and stalls on RAW or WAW hazards. It also caps outstanding memory operations, holds issue after control-flow instructions until the PC redirect arrives, and parks in a trap state on decode errors or ecall/ebreak until flushed.

---
 rtl/rv_pkg.sv | 42 ++++
 rtl/issue_ctrl_if.sv | 37 +++
 rtl/issue_scoreboard.sv | 56 +++++
 rtl/issue_ctrl.sv | 152 +++++++++++++++
 tb/tb_issue_ctrl.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the issue controller.
// Holds the decoder enable bit positions, the special-instruction code,
// the trap-cause code and the issue FSM state encoding.
package rv_pkg;

    // Bit positions within the decoder enable vector
    localparam int unsigned EN_RS1    = 0;
    localparam int unsigned EN_RS2    = 1;
    localparam int unsigned EN_RD     = 2;
    localparam int unsigned EN_MREAD  = 3;
    localparam int unsigned EN_MWRITE = 4;
    localparam int unsigned EN_WIDTH  = 5;

    typedef enum logic [2:0] {
        SpecBr    = 3'd0,
        SpecJal   = 3'd1,
        SpecJalr  = 3'd2,
        SpecAuipc = 3'd3,
        SpecLui   = 3'd4,
        SpecStore = 3'd5,
        SpecLoad  = 3'd6,
        SpecNone  = 3'd7
    } specinst_e;

    typedef enum logic [1:0] {
        CauseDecode = 2'd0,
        CauseEcall  = 2'd1,
        CauseEbreak = 2'd2
    } trap_cause_e;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StWaitBr = 2'd1,
        StTrap   = 2'd2
    } issue_state_e;

    // Instructions whose next PC is unknown until execute resolves them
    function automatic logic is_ctrl_flow(input logic [2:0] spec);
        return (spec == SpecBr) || (spec == SpecJal) || (spec == SpecJalr);
    endfunction

endpackage

// File: rtl/issue_ctrl_if.sv
// Decoder/execute side signals of the issue controller.
// master: the environment (decoder, execute, writeback, trap handler).
// slave : the issue controller itself.
// Signal suffixes (_i/_o) are named from the controller's point of view.
interface issue_ctrl_if #(
    parameter int unsigned RF_SIZE = 5
) ();
    logic                   inst_valid_i;
    logic                   inst_ready_o;
    logic [4:0]             enable_i;
    logic [3*RF_SIZE-1:0]   regi_i;
    logic [2:0]             specinst_i;
    logic                   decode_error_i;
    logic [1:0]             env_exception_i;
    logic                   issue_valid_o;
    logic                   issue_ready_i;
    logic                   wb_valid_i;
    logic [RF_SIZE-1:0]     wb_rd_i;
    logic                   mem_done_i;
    logic                   redirect_i;
    logic                   flush_i;
    logic                   trap_o;
    logic [1:0]             trap_cause_o;
    logic                   busy_o;

    modport master (
        output inst_valid_i, enable_i, regi_i, specinst_i, decode_error_i, env_exception_i,
        output issue_ready_i, wb_valid_i, wb_rd_i, mem_done_i, redirect_i, flush_i,
        input  inst_ready_o, issue_valid_o, trap_o, trap_cause_o, busy_o
    );

    modport slave (
        input  inst_valid_i, enable_i, regi_i, specinst_i, decode_error_i, env_exception_i,
        input  issue_ready_i, wb_valid_i, wb_rd_i, mem_done_i, redirect_i, flush_i,
        output inst_ready_o, issue_valid_o, trap_o, trap_cause_o, busy_o
    );
endinterface

// File: rtl/issue_scoreboard.sv
// Pending-writeback scoreboard: one bit per architectural register.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   set_en / set_idx    mark a register as pending (issue with a destination)
//   clr_en / clr_idx    retire a pending register (writeback)
//   rs1/rs2/rd_idx      lookup indices
//   rs1/rs2/rd_pend     registered pending state of the looked-up registers
//   any_pend            at least one register is pending
module issue_scoreboard #(
    parameter int unsigned RF_SIZE = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               set_en,
    input  logic [RF_SIZE-1:0] set_idx,
    input  logic               clr_en,
    input  logic [RF_SIZE-1:0] clr_idx,
    input  logic [RF_SIZE-1:0] rs1_idx,
    input  logic [RF_SIZE-1:0] rs2_idx,
    input  logic [RF_SIZE-1:0] rd_idx,
    output logic               rs1_pend,
    output logic               rs2_pend,
    output logic               rd_pend,
    output logic               any_pend
);
    localparam int unsigned NUM_REGS = 1 << RF_SIZE;

    logic [NUM_REGS-1:0] sb_q, sb_d;

    always_comb begin
        sb_d = sb_q;
        if (clr_en) begin
            sb_d[clr_idx] = 1'b0;
        end
        // Set is applied after clear so it wins on a same-index collision
        if (set_en) begin
            sb_d[set_idx] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    // Lookups see only the registered state: no writeback bypass
    assign rs1_pend = sb_q[rs1_idx];
    assign rs2_pend = sb_q[rs2_idx];
    assign rd_pend  = sb_q[rd_idx];
    assign any_pend = |sb_q;

endmodule

// File: rtl/issue_ctrl.sv
// Issue controller between decode and execute.
// Stalls on RAW/WAW hazards against the pending-writeback scoreboard, caps
// outstanding memory operations, holds after control-flow instructions until
// the PC redirect, and parks in a trap state on decode errors / ecall / ebreak
// until flushed.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        issue_ctrl_if.slave: decoder handshake, execute handshake,
//              writeback/memory retirement, redirect/flush, trap and busy status
module issue_ctrl
    import rv_pkg::*;
#(
    parameter int unsigned RF_SIZE = 5,
    parameter int unsigned MAX_MEM = 4
) (
    input  logic          clk,
    input  logic          rst,
    issue_ctrl_if.slave   bus
);
    localparam int unsigned CNT_W = 4;

    issue_state_e state_q, state_d;
    trap_cause_e  cause_q, cause_d;
    logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;

    logic [RF_SIZE-1:0] rs1, rs2, rd;
    logic rs1_pend, rs2_pend, rd_pend, any_pend;
    logic rd_nz, hazard, is_mem, mem_stall, trap_cond;
    logic in_run, issue_fire, trap_take, mem_inc, mem_dec;
    trap_cause_e cause_sel;

    assign rs1 = bus.regi_i[0*RF_SIZE +: RF_SIZE];
    assign rs2 = bus.regi_i[1*RF_SIZE +: RF_SIZE];
    assign rd  = bus.regi_i[2*RF_SIZE +: RF_SIZE];

    assign rd_nz = (rd != '0);

    issue_scoreboard #(
        .RF_SIZE (RF_SIZE)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (issue_fire && bus.enable_i[EN_RD] && rd_nz),
        .set_idx  (rd),
        .clr_en   (bus.wb_valid_i),
        .clr_idx  (bus.wb_rd_i),
        .rs1_idx  (rs1),
        .rs2_idx  (rs2),
        .rd_idx   (rd),
        .rs1_pend (rs1_pend),
        .rs2_pend (rs2_pend),
        .rd_pend  (rd_pend),
        .any_pend (any_pend)
    );

    assign hazard = (bus.enable_i[EN_RS1] && rs1_pend) ||
                    (bus.enable_i[EN_RS2] && rs2_pend) ||
                    (bus.enable_i[EN_RD] && rd_nz && rd_pend);

    assign is_mem    = bus.enable_i[EN_MREAD] || bus.enable_i[EN_MWRITE];
    assign mem_stall = is_mem && (mem_cnt_q == CNT_W'(MAX_MEM));
    assign trap_cond = bus.decode_error_i || (|bus.env_exception_i);
    assign in_run    = (state_q == StRun);

    assign issue_fire = bus.issue_valid_o && bus.issue_ready_i;
    assign trap_take  = bus.inst_valid_i && in_run && trap_cond;

    always_comb begin
        if (bus.decode_error_i) begin
            cause_sel = CauseDecode;
        end else if (bus.env_exception_i[0]) begin
            cause_sel = CauseEcall;
        end else begin
            cause_sel = CauseEbreak;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            cause_q <= CauseDecode;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        unique case (state_q)
            StRun: begin
                if (trap_take) begin
                    state_d = StTrap;
                    cause_d = cause_sel;
                end else if (issue_fire && is_ctrl_flow(bus.specinst_i)) begin
                    state_d = StWaitBr;
                end
            end
            StWaitBr: begin
                if (bus.redirect_i) begin
                    state_d = StRun;
                end
            end
            StTrap: begin
                state_d = StTrap;
            end
            default: begin
                state_d = StRun;
            end
        endcase
        // Flush overrides everything, including a trap taken this cycle
        if (bus.flush_i) begin
            state_d = StRun;
            cause_d = CauseDecode;
        end
    end

    // FSM outputs
    always_comb begin
        bus.issue_valid_o = bus.inst_valid_i && in_run && !hazard && !mem_stall && !trap_cond;
        bus.inst_ready_o  = (bus.issue_valid_o && bus.issue_ready_i) || trap_take;
        bus.trap_o        = (state_q == StTrap);
        bus.trap_cause_o  = cause_q;
    end

    // Outstanding memory operation counter
    assign mem_inc = issue_fire && is_mem;
    assign mem_dec = bus.mem_done_i && (mem_cnt_q != '0);

    always_comb begin
        mem_cnt_d = mem_cnt_q;
        if (mem_inc && !mem_dec) begin
            mem_cnt_d = mem_cnt_q + 1'b1;
        end else if (mem_dec && !mem_inc) begin
            mem_cnt_d = mem_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_cnt_q <= '0;
        end else begin
            mem_cnt_q <= mem_cnt_d;
        end
    end

    assign bus.busy_o = any_pend || (mem_cnt_q != '0);

endmodule

// File: tb/tb_issue_ctrl.sv
module tb_issue_ctrl;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    issue_ctrl_if #(.RF_SIZE(5)) bus ();

    issue_ctrl #(
        .RF_SIZE (5),
        .MAX_MEM (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string      name;
        logic       iv;
        logic       ir;
        logic       tr;
        logic [1:0] ca;
        logic       bz;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [4:0] EN_ALU  = 5'b00111;
    localparam logic [4:0] EN_IMM  = 5'b00101;
    localparam logic [4:0] EN_RDO  = 5'b00100;
    localparam logic [4:0] EN_LOAD = 5'b01101;

    task automatic check(input string nm, input string fld, input logic [1:0] act,
                         input logic [1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, req);
        end
    endtask

    // Monitor: compares the DUT outputs against the expectation queued for this cycle
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.name, "issue_valid", {1'b0, bus.issue_valid_o}, {1'b0, e.iv});
            check(e.name, "inst_ready",  {1'b0, bus.inst_ready_o},  {1'b0, e.ir});
            check(e.name, "trap",        {1'b0, bus.trap_o},        {1'b0, e.tr});
            check(e.name, "trap_cause",  bus.trap_cause_o,          e.ca);
            check(e.name, "busy",        {1'b0, bus.busy_o},        {1'b0, e.bz});
        end
    end

    task automatic inst(input logic v, input logic [4:0] en, input int rs1, input int rs2,
                        input int rd, input logic [2:0] sp, input logic rdy);
        bus.inst_valid_i    = v;
        bus.enable_i        = en;
        bus.regi_i          = {5'(rd), 5'(rs2), 5'(rs1)};
        bus.specinst_i      = sp;
        bus.issue_ready_i   = rdy;
        bus.decode_error_i  = 1'b0;
        bus.env_exception_i = 2'b00;
    endtask

    task automatic idle();
        inst(1'b0, 5'b0, 0, 0, 0, 3'd7, 1'b1);
    endtask

    task automatic wb(input int r);
        bus.wb_valid_i = 1'b1;
        bus.wb_rd_i    = 5'(r);
    endtask

    // Queue the expectation for the cycle being driven, then advance one cycle
    task automatic step(input string nm, input logic iv, input logic ir, input logic tr,
                        input logic [1:0] ca, input logic bz);
        exp_t e;
        e.name = nm; e.iv = iv; e.ir = ir; e.tr = tr; e.ca = ca; e.bz = bz;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        rst            = 1'b0;
        bus.wb_valid_i = 1'b0;
        bus.mem_done_i = 1'b0;
        bus.redirect_i = 1'b0;
        bus.flush_i    = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        bus.wb_valid_i = 1'b0;
        bus.wb_rd_i    = '0;
        bus.mem_done_i = 1'b0;
        bus.redirect_i = 1'b0;
        bus.flush_i    = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        step("reset_state", 0, 0, 0, 0, 0);

        // add x5,x1,x2 issues immediately
        inst(1, EN_ALU, 1, 2, 5, 3'd7, 1);  step("add_issue", 1, 1, 0, 0, 0);
        idle();                             step("sb5_busy", 0, 0, 0, 0, 1);
        // addi x6,x5,1: RAW on x5, no same-cycle writeback bypass
        inst(1, EN_IMM, 5, 0, 6, 3'd7, 1);  step("raw_stall", 0, 0, 0, 0, 1);
        wb(5);                              step("raw_no_bypass", 0, 0, 0, 0, 1);
        step("raw_release", 1, 1, 0, 0, 0);
        idle(); wb(6);                      step("wb6", 0, 0, 0, 0, 1);
        // valid held while execute not ready
        inst(1, EN_ALU, 3, 4, 7, 3'd7, 0);  step("hold_not_ready", 1, 0, 0, 0, 0);
        bus.issue_ready_i = 1'b1;           step("hold_accept", 1, 1, 0, 0, 0);
        idle(); wb(7);                      step("wb7", 0, 0, 0, 0, 1);
        // x0 destination never marks the scoreboard
        inst(1, EN_IMM, 0, 0, 0, 3'd7, 1);  step("x0_issue", 1, 1, 0, 0, 0);
        idle(); wb(9);                      step("x0_no_sb", 0, 0, 0, 0, 0);
        idle();                             step("wb_nonpending", 0, 0, 0, 0, 0);

        // Memory cap of 4
        inst(1, EN_LOAD, 0, 0, 10, 3'd6, 1); step("load1", 1, 1, 0, 0, 0);
        inst(1, EN_LOAD, 0, 0, 11, 3'd6, 1); step("load2", 1, 1, 0, 0, 1);
        inst(1, EN_LOAD, 0, 0, 12, 3'd6, 1); step("load3", 1, 1, 0, 0, 1);
        inst(1, EN_LOAD, 0, 0, 13, 3'd6, 1); step("load4", 1, 1, 0, 0, 1);
        inst(1, EN_LOAD, 0, 0, 14, 3'd6, 1); step("mem_cap", 0, 0, 0, 0, 1);
        bus.mem_done_i = 1'b1;               step("mem_cap_done", 0, 0, 0, 0, 1);
        bus.mem_done_i = 1'b1;               step("load_and_done", 1, 1, 0, 0, 1);
        inst(1, EN_LOAD, 0, 0, 15, 3'd6, 1); step("load6", 1, 1, 0, 0, 1);
        inst(1, EN_LOAD, 0, 0, 16, 3'd6, 1); step("mem_cap_again", 0, 0, 0, 0, 1);

        // Reset mid-operation drops scoreboard and counter
        idle(); rst = 1'b1;                  step("pre_reset_busy", 0, 0, 0, 0, 1);
        idle();                              step("reset_clears", 0, 0, 0, 0, 0);

        // mem_done with an empty counter must not underflow
        bus.mem_done_i = 1'b1;               step("done_at_zero", 0, 0, 0, 0, 0);
        inst(1, EN_LOAD, 0, 0, 10, 3'd6, 1); step("load_zero", 1, 1, 0, 0, 0);
        idle(); bus.mem_done_i = 1'b1; wb(10); step("load_busy", 0, 0, 0, 0, 1);
        idle();                              step("drained", 0, 0, 0, 0, 0);

        // Control flow: jal x1 holds issue until redirect
        inst(1, EN_RDO, 0, 0, 1, 3'd1, 1);   step("jal_issue", 1, 1, 0, 0, 0);
        inst(1, EN_ALU, 3, 4, 2, 3'd7, 1); wb(1); step("wait_br_hold", 0, 0, 0, 0, 1);
        bus.redirect_i = 1'b1;               step("redirect_cycle", 0, 0, 0, 0, 0);
        step("resume", 1, 1, 0, 0, 0);
        idle(); wb(2);                       step("idle_wb2", 0, 0, 0, 0, 1);

        // Traps
        inst(1, 5'b0, 0, 0, 0, 3'd7, 0); bus.env_exception_i = 2'b01;
        step("ecall_consume", 0, 1, 0, 0, 0);
        inst(1, EN_ALU, 3, 4, 2, 3'd7, 1); bus.redirect_i = 1'b1;
        step("redirect_in_trap", 0, 0, 1, 1, 0);
        bus.flush_i = 1'b1; bus.redirect_i = 1'b1;
        step("flush_cycle", 0, 0, 1, 1, 0);
        step("after_flush", 1, 1, 0, 0, 0);
        inst(1, 5'b0, 0, 0, 0, 3'd7, 1); bus.decode_error_i = 1'b1;
        bus.env_exception_i = 2'b10; wb(2);
        step("derr_consume", 0, 1, 0, 0, 1);
        idle();                              step("cause_derr", 0, 0, 1, 0, 0);
        bus.flush_i = 1'b1;                  step("flush2", 0, 0, 1, 0, 0);
        inst(1, 5'b0, 0, 0, 0, 3'd7, 1); bus.env_exception_i = 2'b10;
        step("ebreak_consume", 0, 1, 0, 0, 0);
        idle();                              step("cause_ebreak", 0, 0, 1, 2, 0);
        bus.flush_i = 1'b1;                  step("flush3", 0, 0, 1, 2, 0);
        inst(1, 5'b0, 0, 0, 0, 3'd7, 1); bus.env_exception_i = 2'b11;
        step("both_consume", 0, 1, 0, 0, 0);
        idle();                              step("cause_priority", 0, 0, 1, 1, 0);
        bus.flush_i = 1'b1;                  step("flush4", 0, 0, 1, 1, 0);
        idle();                              step("trap_clear", 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
